// File: rtl/dma_write_engine.sv
// dma_write_engine: streaming DMA writer for CCI-P channel 1.
// Words from the compute core are buffered in a small FIFO. Each word is then
// written as one single-line WrLine to consecutive cache lines starting at the
// base address latched on start. Write responses are counted, and done pulses
// once every line has been acknowledged.
// Optional feature macro: DMA_WRITE_MAX_OUTSTANDING_EN caps the number of
// in-flight writes at MAX_OUTSTANDING.
//
// Handshake: a word is consumed on any rising edge where in_valid && in_ready.
// in_ready does not depend on in_valid. c1tx_valid is a one-cycle strobe with
// no ready; flow control comes only through c1TxAlmFull, which is sampled
// before each request is issued.
module dma_write_engine #(
  parameter int ADDR_WIDTH      = 42,
  parameter int DATA_WIDTH      = 512,
  parameter int FIFO_DEPTH      = 16,
  parameter int MDATA_WIDTH     = 16,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  dst_addr,
  input  logic [31:0]            dst_ncl,
  input  logic                   start,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   c1TxAlmFull,
  output logic                   c1tx_valid,
  output logic [ADDR_WIDTH-1:0]  c1tx_addr,
  output logic [DATA_WIDTH-1:0]  c1tx_data,
  output logic [MDATA_WIDTH-1:0] c1tx_mdata,
  input  logic                   c1rx_rspValid,
  output logic                   done,
  output logic                   busy,
  output logic [3:0]             state_out,
  output logic [31:0]            num_req,
  output logic [31:0]            num_rsp
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_RUN   = 4'd1,
    S_DRAIN = 4'd2,
    S_DONE  = 4'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic [31:0]            ncl_q, ncl_d;
  logic [31:0]            acc_q, acc_d;
  logic [31:0]            num_req_q, num_req_d;
  logic [31:0]            num_rsp_q, num_rsp_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   tx_valid_q, tx_valid_d;
  logic [ADDR_WIDTH-1:0]  tx_addr_q, tx_addr_d;
  logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
  logic [MDATA_WIDTH-1:0] tx_mdata_q, tx_mdata_d;

  logic [DATA_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];

  logic fifo_full;
  logic fifo_empty;
  logic in_flight_ok;
  logic issue;
  logic enq;
  logic rsp_count;

  assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);

`ifdef DMA_WRITE_MAX_OUTSTANDING_EN
  // Count in flight uses registered counters, so a response arriving this
  // cycle only frees a slot from the next cycle on.
  assign in_flight_ok = ((num_req_q - num_rsp_q) < 32'(MAX_OUTSTANDING));
`else
  logic [31:0] unused_max_outstanding;
  assign unused_max_outstanding = 32'(MAX_OUTSTANDING);
  assign in_flight_ok = 1'b1;
`endif

  // Issue one buffered word per cycle while the job still needs requests.
  assign issue = (state_q == S_RUN) && !fifo_empty && !c1TxAlmFull &&
                 (num_req_q < ncl_q) && in_flight_ok;

  // A full FIFO can still take a word when a dequeue frees a slot this cycle.
  assign in_ready  = (state_q == S_RUN) && (!fifo_full || issue) && (acc_q < ncl_q);
  assign enq       = in_valid && in_ready;
  assign rsp_count = c1rx_rspValid && ((state_q == S_RUN) || (state_q == S_DRAIN)) &&
                     (num_rsp_q < ncl_q);

  assign c1tx_valid = tx_valid_q;
  assign c1tx_addr  = tx_addr_q;
  assign c1tx_data  = tx_data_q;
  assign c1tx_mdata = tx_mdata_q;
  assign done       = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign state_out  = state_q;
  assign num_req    = num_req_q;
  assign num_rsp    = num_rsp_q;

  // Next-state, FIFO pointer, counter and request-register logic.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    ncl_d      = ncl_q;
    acc_d      = acc_q;
    num_req_d  = num_req_q;
    num_rsp_d  = num_rsp_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    tx_valid_d = 1'b0;
    tx_addr_d  = '0;
    tx_data_d  = '0;
    tx_mdata_d = '0;

    if (enq) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      acc_d    = acc_q + 32'd1;
    end

    if (issue) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      num_req_d  = num_req_q + 32'd1;
      tx_valid_d = 1'b1;
      tx_addr_d  = base_q + ADDR_WIDTH'(num_req_q);
      tx_data_d  = fifo_mem[rd_ptr_q];
      tx_mdata_d = num_req_q[MDATA_WIDTH-1:0];
    end

    case ({enq, issue})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    if (rsp_count) begin
      num_rsp_d = num_rsp_q + 32'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d    = dst_addr;
          ncl_d     = dst_ncl;
          acc_d     = '0;
          num_req_d = '0;
          num_rsp_d = '0;
          state_d   = (dst_ncl == 32'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (issue && ((num_req_q + 32'd1) == ncl_q)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (num_rsp_q == ncl_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and control registers; reset flushes the FIFO and clears outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      ncl_q      <= '0;
      acc_q      <= '0;
      num_req_q  <= '0;
      num_rsp_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_addr_q  <= '0;
      tx_data_q  <= '0;
      tx_mdata_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      ncl_q      <= ncl_d;
      acc_q      <= acc_d;
      num_req_q  <= num_req_d;
      num_rsp_q  <= num_rsp_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_addr_q  <= tx_addr_d;
      tx_data_q  <= tx_data_d;
      tx_mdata_q <= tx_mdata_d;
    end
  end

  // Buffer storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_mem[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_dma_write_engine.sv
// Bench for dma_write_engine: table of write jobs plus hand-written sequences
// for zero-length jobs, mid-job reset and (with DMA_WRITE_MAX_OUTSTANDING_EN)
// the in-flight limit. Expected requests are queued as words are accepted
// and popped as the engine emits them.
module tb_dma_write_engine;

  localparam int AW    = 42;
  localparam int DW    = 512;
  localparam int MW    = 16;
  localparam int DEPTH = 16;
  localparam int REQ_W = AW + MW + DW;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] dst_addr;
  logic [31:0]   dst_ncl;
  logic          start;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          c1TxAlmFull;
  logic          c1tx_valid;
  logic [AW-1:0] c1tx_addr;
  logic [DW-1:0] c1tx_data;
  logic [MW-1:0] c1tx_mdata;
  logic          c1rx_rspValid;
  logic          done;
  logic          busy;
  logic [3:0]    state_out;
  logic [31:0]   num_req;
  logic [31:0]   num_rsp;

  dma_write_engine #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .MDATA_WIDTH(MW),
`ifdef DMA_WRITE_MAX_OUTSTANDING_EN
    .MAX_OUTSTANDING(2)
`else
    .MAX_OUTSTANDING(64)
`endif
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .dst_addr     (dst_addr),
    .dst_ncl      (dst_ncl),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .c1TxAlmFull  (c1TxAlmFull),
    .c1tx_valid   (c1tx_valid),
    .c1tx_addr    (c1tx_addr),
    .c1tx_data    (c1tx_data),
    .c1tx_mdata   (c1tx_mdata),
    .c1rx_rspValid(c1rx_rspValid),
    .done         (done),
    .busy         (busy),
    .state_out    (state_out),
    .num_req      (num_req),
    .num_rsp      (num_rsp)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cycle = 0;
  initial forever begin
    @(posedge clk);
    cycle++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  logic [REQ_W-1:0] exp_q[$];
  int rsp_due_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  int req_seen, done_cnt, busy_cnt, first_req, last_req, start_cycle;
  int done_cycle, last_rsp_cycle, rsp_delay, alm_at, alm_cnt, rsp_inject;
  int job_acc, job_ncl;
  logic [AW-1:0] job_base;
  bit auto_rsp, feed_abort, feed_busy, mon_en;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom();
    return w;
  endfunction

  // ---------------- monitor / response driver ----------------
  initial begin
    logic [REQ_W-1:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (c1TxAlmFull) check("almfull_block", c1tx_valid, 0);
        check("done_is_state3", done, state_out == 4'd3);
        if (busy) busy_cnt++;
        if (done) begin
          done_cnt++;
          done_cycle = cycle;
        end
        if (alm_cnt > 0) begin
          if (alm_cnt == 1) begin
            check("fifo_fill", job_acc - req_seen, DEPTH);
            check("in_ready_full", in_ready, 0);
          end
          alm_cnt--;
          if (alm_cnt == 0) c1TxAlmFull = 1'b0;
        end
        if (c1tx_valid) begin
          req_seen++;
          if (req_seen == 1) first_req = cycle;
          last_req = cycle;
          if (exp_q.size() == 0) begin
            check("unexpected_req", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("req_addr",  c1tx_addr,  e[REQ_W-1 -: AW]);
            check("req_mdata", c1tx_mdata, e[DW+MW-1 -: MW]);
            check("req_data",  c1tx_data,  e[DW-1:0]);
          end
          if (auto_rsp) rsp_due_q.push_back(cycle + rsp_delay);
          if (alm_at != 0 && req_seen == alm_at) begin
            c1TxAlmFull = 1'b1;
            alm_cnt = 20;
          end
        end else begin
          check("tx_idle_zero", (|c1tx_addr) | (|c1tx_data) | (|c1tx_mdata), 0);
        end
      end
      if (rsp_inject > 0) begin
        c1rx_rspValid = 1'b1;
        rsp_inject--;
        last_rsp_cycle = cycle;
      end else if (rsp_due_q.size() > 0 && rsp_due_q[0] <= cycle) begin
        void'(rsp_due_q.pop_front());
        c1rx_rspValid = 1'b1;
        last_rsp_cycle = cycle;
      end else begin
        c1rx_rspValid = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic feed(input int n, input int budget);
    int i = 0;
    int t = 0;
    logic [DW-1:0] w;
    w = rand_word();
    while (i < n && t < budget && !feed_abort) begin
      in_valid = 1'b1;
      in_data  = w;
      #4;
      if (i >= job_ncl) check("in_ready_cap", in_ready, 0);
      if (in_ready && !feed_abort) begin
        exp_q.push_back({AW'(job_base + AW'(i)), i[MW-1:0], w});
        i++;
        job_acc = i;
        w = rand_word();
      end
      @(negedge clk);
      t++;
    end
    in_valid  = 1'b0;
    in_data   = '0;
    feed_busy = 1'b0;
  endtask

  task automatic start_job(input logic [AW-1:0] a, input int n, input int words, input int budget);
    @(negedge clk);
    req_seen = 0; done_cnt = 0; busy_cnt = 0; job_acc = 0;
    first_req = -1; last_req = -1; last_rsp_cycle = -1; done_cycle = -1;
    job_base = a; job_ncl = n;
    dst_addr = a; dst_ncl = n; start = 1'b1;
    start_cycle = cycle;
    feed_busy = 1'b1;
    fork
      feed(words, budget);
    join_none
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while ((done_cnt == 0 || feed_busy) && t < budget) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("job_finished_in_time", (done_cnt != 0) && !feed_busy, 1);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  in_ready,   0);
    check({tag, "_tx_valid"},  c1tx_valid, 0);
    check({tag, "_tx_addr"},   c1tx_addr,  0);
    check({tag, "_tx_data"},   c1tx_data,  0);
    check({tag, "_tx_mdata"},  c1tx_mdata, 0);
    check({tag, "_done"},      done,       0);
    check({tag, "_busy"},      busy,       0);
    check({tag, "_state"},     state_out,  0);
    check({tag, "_num_req"},   num_req,    0);
    check({tag, "_num_rsp"},   num_rsp,    0);
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    int ncl;
    int delay;
    int alm;
    int words;
    int exp_acc;
  } job_t;

  task automatic run_job(input job_t j);
    rsp_delay = j.delay;
    alm_at    = j.alm;
    auto_rsp  = 1'b1;
    start_job(j.addr, j.ncl, j.words, (j.words > j.ncl) ? 12 : 200);
    wait_idle(400);
    check("job_done_count", done_cnt, 1);
    check("job_req_seen",   req_seen, j.ncl);
    check("job_num_req",    num_req,  j.ncl);
    check("job_num_rsp",    num_rsp,  j.ncl);
    check("job_accepted",   job_acc,  j.exp_acc);
    check("job_exp_left",   exp_q.size(), 0);
    check("job_state_idle", state_out, 0);
    check("job_first_lat",  first_req - start_cycle, 3);
    check("job_done_gap",   done_cycle - last_rsp_cycle, 2);
`ifndef DMA_WRITE_MAX_OUTSTANDING_EN
    if (j.alm == 0) check("job_back_to_back", last_req - first_req, j.ncl - 1);
`endif
  endtask

  // ---------------- test sequence ----------------
  job_t jobs[5];

  initial begin
    jobs[0] = '{addr: 42'h1000,          ncl: 4,  delay: 3, alm: 0, words: 4,  exp_acc: 4};
    jobs[1] = '{addr: 42'h3FF_FFFF_FFFE, ncl: 5,  delay: 1, alm: 0, words: 5,  exp_acc: 5};
    jobs[2] = '{addr: 42'h2000,          ncl: 32, delay: 3, alm: 3, words: 32, exp_acc: 32};
    jobs[3] = '{addr: 42'h4000,          ncl: 2,  delay: 2, alm: 0, words: 5,  exp_acc: 2};
    jobs[4] = '{addr: 42'h1_2345_6780,   ncl: 7,  delay: 5, alm: 0, words: 7,  exp_acc: 7};

    reset = 1'b1; start = 1'b0; dst_addr = '0; dst_ncl = '0;
    in_data = '0; in_valid = 1'b0; c1TxAlmFull = 1'b0; c1rx_rspValid = 1'b0;
    rsp_inject = 0; alm_cnt = 0; alm_at = 0; rsp_delay = 1;
    auto_rsp = 1'b1; feed_abort = 1'b0; feed_busy = 1'b0; mon_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("por");
    reset = 1'b0;
    mon_en = 1'b1;

    for (int k = 0; k < 5; k++) run_job(jobs[k]);

    // Zero-length job: straight to DONE for one cycle, no requests.
    start_job(42'h5000, 0, 0, 1);
    repeat (4) @(negedge clk);
    #1;
    check("ncl0_done_count", done_cnt, 1);
    check("ncl0_done_cycle", done_cycle - start_cycle, 1);
    check("ncl0_busy_cycles", busy_cnt, 1);
    check("ncl0_no_req", req_seen, 0);

    // Reset after the third request while responses are still pending.
    rsp_delay = 8;
    alm_at = 0;
    start_job(42'h8000, 8, 8, 200);
    begin
      int t = 0;
      while (req_seen < 3 && t < 100) begin
        @(negedge clk);
        #1;
        t++;
      end
    end
    check("rst_reached_req3", req_seen, 3);
    feed_abort = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outputs("midrst");
    reset = 1'b0;
    exp_q.delete();
    repeat (15) @(negedge clk);
    #1;
    check("midrst_late_rsp_num_rsp", num_rsp, 0);
    check("midrst_late_rsp_num_req", num_req, 0);
    check("midrst_state_idle", state_out, 0);
    check("midrst_no_done", done_cnt, 0);
    check("midrst_feeder_stopped", feed_busy, 0);
    feed_abort = 1'b0;
    run_job('{addr: 42'h9000, ncl: 1, delay: 2, alm: 0, words: 1, exp_acc: 1});

`ifdef DMA_WRITE_MAX_OUTSTANDING_EN
    // In-flight cap of 2 with responses withheld and released one by one.
    auto_rsp = 1'b0;
    alm_at = 0;
    start_job(42'hA000, 6, 6, 200);
    repeat (10) @(negedge clk);
    #1;
    check("maxout_initial_reqs", req_seen, 2);
    for (int k = 1; k <= 6; k++) begin
      rsp_inject = 1;
      repeat (5) @(negedge clk);
      #1;
      check("maxout_reqs_after_rsp", req_seen, (k + 2 > 6) ? 6 : k + 2);
      check("maxout_done_after_rsp", done_cnt, (k == 6) ? 1 : 0);
    end
    check("maxout_num_rsp", num_rsp, 6);
    check("maxout_exp_left", exp_q.size(), 0);
    auto_rsp = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
